cordic_vectoring: RTL and testbench

- Iterative CORDIC in vectoring mode, the inverse of the team's rotation-mode sin/cos unit: takes a Cartesian vector (X, Y) and returns its angle (atan2) and gain-compensated magnitude.
- Uses the same fixed-point conventions: Q3.12 data (4096 = 1.0) and 16-bit binary angle (65536 = 360°, 16384 = 90°).
- Sits after the sin/cos unit or a vector source.
- Single-request handshake: i_Valid in, o_Busy/o_Done out.

---
 rtl/cordic_vectoring.sv | 161 ++++++++++++++++
 tb/tb_cordic_vectoring.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC, vectoring mode: converts a Q3.12 Cartesian vector (X, Y)
// into its 16-bit binary angle (65536 = 360 deg) and gain-compensated
// magnitude (Q4.12). One micro-rotation per clock, then a single scaling step.
module cordic_vectoring #(
   parameter int unsigned N_ITER = 12,
   parameter int unsigned K_INV  = 2487
) (
   input  logic        i_clock,
   input  logic        i_Reset,
   input  logic        i_Valid,
   input  logic [15:0] i_X,
   input  logic [15:0] i_Y,
   output logic [15:0] o_Theta,
   output logic [16:0] o_Mag,
   output logic        o_Busy,
   output logic        o_Done
);

   typedef enum logic [1:0] {StIdle, StCalc, StScale} state_e;

   state_e             state_q;
   logic signed [17:0] x_q;
   logic signed [17:0] y_q;
   logic        [15:0] z_q;
   logic        [3:0]  iter_q;
   logic               zero_q;

   logic signed [17:0] x_ext;
   logic signed [17:0] y_ext;
   logic signed [17:0] x_pre;
   logic signed [17:0] y_pre;
   logic        [15:0] z_pre;
   logic signed [17:0] x_sh;
   logic signed [17:0] y_sh;
   logic signed [17:0] x_calc;
   logic signed [17:0] y_calc;
   logic        [15:0] z_calc;
   logic        [15:0] alpha;
   logic        [29:0] mag_prod;
   logic        [16:0] mag_next;
   logic               last_iter;

   // Extend before any negation so that -32768 inputs stay exact.
   assign x_ext = {{2{i_X[15]}}, i_X};
   assign y_ext = {{2{i_Y[15]}}, i_Y};

   assign x_sh = x_q >>> iter_q;
   assign y_sh = y_q >>> iter_q;

   // x is non-negative after pre-rotation, so zero-extending it is safe.
   assign mag_prod = {12'd0, x_q} * 30'(K_INV);
   assign mag_next = 17'(mag_prod >> 12);

   assign last_iter = (iter_q == 4'(N_ITER - 1));

   // Arctangent table, atan(2^-i) in binary-angle units.
   always_comb begin
      alpha = 16'd0;
      case (iter_q)
         4'd0:    alpha = 16'd8192;
         4'd1:    alpha = 16'd4836;
         4'd2:    alpha = 16'd2555;
         4'd3:    alpha = 16'd1297;
         4'd4:    alpha = 16'd651;
         4'd5:    alpha = 16'd326;
         4'd6:    alpha = 16'd163;
         4'd7:    alpha = 16'd81;
         4'd8:    alpha = 16'd41;
         4'd9:    alpha = 16'd20;
         4'd10:   alpha = 16'd10;
         4'd11:   alpha = 16'd5;
         default: alpha = 16'd0;
      endcase
   end

   // Pre-rotation by +/-90 deg brings the vector into the right half-plane.
   always_comb begin
      x_pre = x_ext;
      y_pre = y_ext;
      z_pre = 16'd0;
      if (x_ext[17]) begin
         if (!y_ext[17]) begin
            x_pre = y_ext;
            y_pre = -x_ext;
            z_pre = 16'd16384;
         end else begin
            x_pre = -y_ext;
            y_pre = x_ext;
            z_pre = 16'd49152;
         end
      end
   end

   // One micro-rotation driving y toward zero, accumulating the angle in z.
   always_comb begin
      x_calc = x_q;
      y_calc = y_q;
      z_calc = z_q;
      if (!y_q[17]) begin
         x_calc = x_q + y_sh;
         y_calc = y_q - x_sh;
         z_calc = z_q + alpha;
      end else begin
         x_calc = x_q - y_sh;
         y_calc = y_q + x_sh;
         z_calc = z_q - alpha;
      end
   end

   // Control FSM with datapath and registered outputs.
   always_ff @(posedge i_clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         iter_q  <= '0;
         zero_q  <= 1'b0;
         o_Theta <= '0;
         o_Mag   <= '0;
         o_Busy  <= 1'b0;
         o_Done  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               o_Done <= 1'b0;
               if (i_Valid) begin
                  x_q     <= x_pre;
                  y_q     <= y_pre;
                  z_q     <= z_pre;
                  iter_q  <= '0;
                  // A null vector would otherwise sum the whole angle table.
                  zero_q  <= (i_X == 16'd0) && (i_Y == 16'd0);
                  o_Busy  <= 1'b1;
                  state_q <= StCalc;
               end
            end
            StCalc: begin
               x_q    <= x_calc;
               y_q    <= y_calc;
               z_q    <= z_calc;
               iter_q <= iter_q + 4'd1;
               if (last_iter) begin
                  state_q <= StScale;
               end
            end
            StScale: begin
               o_Theta <= zero_q ? 16'd0 : z_q;
               o_Mag   <= mag_next;
               o_Done  <= 1'b1;
               o_Busy  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: directed axis/quadrant/extreme
// vectors, handshake and mid-calculation reset, plus random vectors checked
// against a floating-point atan2/hypot model.
module tb_cordic_vectoring;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [15:0] xin;
   logic [15:0] yin;
   logic [15:0] theta;
   logic [16:0] mag;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   cordic_vectoring dut (
      .i_clock (clk),
      .i_Reset (rst),
      .i_Valid (valid),
      .i_X     (xin),
      .i_Y     (yin),
      .o_Theta (theta),
      .o_Mag   (mag),
      .o_Busy  (busy),
      .o_Done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_ang(input string tag, input int obs, input int exp);
      int d;
      d = (obs - exp) % 65536;
      if (d < 0) d += 65536;
      if (d > 32768) d = 65536 - d;
      checks++;
      assert (d <= 8)
      else begin
         failures++;
         $error("FAIL %s: theta got %0d expected %0d +/-8", tag, obs, exp);
      end
   endtask

   task automatic chk_mag(input string tag, input int obs, input int exp, input int tol);
      int d;
      d = obs - exp;
      if (d < 0) d = -d;
      checks++;
      assert (d <= tol)
      else begin
         failures++;
         $error("FAIL %s: mag got %0d expected %0d +/-%0d", tag, obs, exp, tol);
      end
   endtask

   // Reference model: ideal angle in binary-angle units and ideal magnitude.
   function automatic int ref_theta(input int x, input int y);
      real th;
      th = $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * 3.14159265358979);
      if (th < 0.0) th += 65536.0;
      return int'(th) % 65536;
   endfunction

   function automatic int ref_mag(input int x, input int y);
      return int'($sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
   endfunction

   // One request with i_Valid for a single cycle; reports edges to o_Done.
   task automatic request(input string tag, input int x, input int y,
                          output int th, output int mg, output int edges);
      @(negedge clk);
      valid = 1'b1;
      xin   = 16'(x);
      yin   = 16'(y);
      @(posedge clk);
      #1;
      valid = 1'b0;
      chk_eq({tag, "_busy"}, int'(busy), 1);
      edges = 0;
      while (!done && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      th = int'(theta);
      mg = int'(mag);
      chk_eq({tag, "_lat"}, edges, 13);
      @(posedge clk);
      #1;
      chk_eq({tag, "_done1"}, int'(done), 0);
   endtask

   initial begin
      int th, mg, ed, x, y, cnt, tries;
      rst   = 1'b1;
      valid = 1'b0;
      xin   = '0;
      yin   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_theta", int'(theta), 0);
      chk_eq("rst_mag", int'(mag), 0);
      chk_eq("rst_busy", int'(busy), 0);
      chk_eq("rst_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;

      // Unit vector along +X.
      request("unit_x", 4096, 0, th, mg, ed);
      chk_ang("unit_x_th", th, 0);
      chk_mag("unit_x_mag", mg, 4096, 8);
      chk_eq("unit_x_idle", int'(busy), 0);

      // Axis and quadrant sweep.
      request("pos_y", 0, 4096, th, mg, ed);
      chk_ang("pos_y_th", th, 16384);
      chk_mag("pos_y_mag", mg, 4096, 8);
      request("neg_x", -4096, 0, th, mg, ed);
      chk_ang("neg_x_th", th, 32768);
      chk_mag("neg_x_mag", mg, 4096, 8);
      request("neg_y", 0, -4096, th, mg, ed);
      chk_ang("neg_y_th", th, 49152);
      chk_mag("neg_y_mag", mg, 4096, 8);
      request("diag", 2896, 2896, th, mg, ed);
      chk_ang("diag_th", th, 8192);
      chk_mag("diag_mag", mg, 4096, 8);

      // Extremes.
      request("ext_nn", -32768, -32768, th, mg, ed);
      chk_ang("ext_nn_th", th, 40960);
      chk_mag("ext_nn_mag", mg, 46341, 50);
      request("ext_pn", 32767, -32768, th, mg, ed);
      chk_ang("ext_pn_th", th, 57344);
      chk_mag("ext_pn_mag", mg, 46341, 50);

      // Held i_Valid with changing inputs: only accept-edge samples count.
      @(negedge clk);
      valid = 1'b1;
      xin   = 16'd0;
      yin   = 16'd4096;
      @(posedge clk);
      #1;
      ed = 0;
      while (!done && ed < 40) begin
         @(negedge clk);
         xin = 16'($urandom);
         yin = 16'($urandom);
         @(posedge clk);
         #1;
         ed++;
      end
      chk_eq("hold_lat", ed, 13);
      chk_ang("hold_th", int'(theta), 16384);
      chk_mag("hold_mag", int'(mag), 4096, 8);
      @(negedge clk);
      xin = 16'(-4096);
      yin = 16'd0;
      @(posedge clk);
      #1;
      chk_eq("b2b_accept", int'(busy), 1);
      chk_eq("b2b_done_pulse", int'(done), 0);
      valid = 1'b0;
      ed = 0;
      while (!done && ed < 40) begin
         @(posedge clk);
         #1;
         ed++;
      end
      chk_eq("b2b_lat", ed, 13);
      chk_ang("b2b_th", int'(theta), 32768);
      chk_mag("b2b_mag", int'(mag), 4096, 8);

      // Asynchronous reset in the middle of a calculation.
      @(negedge clk);
      valid = 1'b1;
      xin   = 16'd8192;
      yin   = 16'd4096;
      @(posedge clk);
      #1;
      valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_eq("arst_theta", int'(theta), 0);
      chk_eq("arst_mag", int'(mag), 0);
      chk_eq("arst_busy", int'(busy), 0);
      chk_eq("arst_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) cnt++;
      end
      chk_eq("arst_no_done", cnt, 0);
      request("post_rst", -2896, 2896, th, mg, ed);
      chk_ang("post_rst_th", th, 24576);
      chk_mag("post_rst_mag", mg, 4096, 8);

      // Zero vector.
      request("zero", 0, 0, th, mg, ed);
      chk_eq("zero_th", th, 0);
      chk_eq("zero_mag", mg, 0);

      // Random vectors of substantial magnitude against the model.
      for (int n = 0; n < 16; n++) begin
         tries = 0;
         do begin
            x = int'($urandom_range(65535, 0)) - 32768;
            y = int'($urandom_range(65535, 0)) - 32768;
            tries++;
         end while ((x * x + y * y < 16384 * 16384) && tries < 100);
         request("rand", x, y, th, mg, ed);
         chk_ang("rand_th", th, ref_theta(x, y));
         chk_mag("rand_mag", mg, ref_mag(x, y), 8 + ref_mag(x, y) / 1000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
